// File: rtl/rptr_empty_buf.sv
// Read-side FIFO pointer/empty logic feeding a 2-entry registered output buffer.
// Latency: rq2_wptr change to out_valid is 2 rclk cycles when the buffer is empty; 1 word/cycle sustained.
// Backpressure: out_ready low holds out_data; memory pops stop once both buffer entries are occupied.
module rptr_empty_buf #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [ASIZE:0]   rq2_wptr,
    input  logic [DSIZE-1:0] rdata,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr,
    output logic             rempty,
    output logic [ASIZE:0]   rlevel,
    output logic [DSIZE-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [ASIZE:0]   rbin;
    logic [ASIZE:0]   rbinnext;
    logic [ASIZE:0]   rgraynext;
    logic [ASIZE:0]   wbin;
    logic [1:0]       obuf_cnt;
    logic [1:0]       obuf_cnt_next;
    logic [DSIZE-1:0] obuf_tail;
    logic             rinc;
    logic             xfer;

    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Pop decision uses the current buffer occupancy so a full buffer never over-pops.
    always_comb begin
        raddr     = rbin[ASIZE-1:0];
        rinc      = !rempty && (obuf_cnt < 2'd2);
        xfer      = out_valid && out_ready;
        rbinnext  = rbin + {{ASIZE{1'b0}}, rinc};
        rgraynext = (rbinnext >> 1) ^ rbinnext;
        wbin      = gray2bin(rq2_wptr);
        case ({rinc, xfer})
            2'b10:   obuf_cnt_next = obuf_cnt + 2'd1;
            2'b01:   obuf_cnt_next = obuf_cnt - 2'd1;
            default: obuf_cnt_next = obuf_cnt;
        endcase
    end

    // Read pointer, empty flag and fill level; the full-width Gray compare separates full from empty.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
            rlevel <= '0;
        end else begin
            rbin   <= rbinnext;
            rptr   <= rgraynext;
            rempty <= (rgraynext == rq2_wptr);
            rlevel <= wbin - rbinnext;
        end
    end

    // Two-entry output buffer: out_data is the head register, obuf_tail holds the second word.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            obuf_cnt  <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            obuf_tail <= '0;
        end else begin
            obuf_cnt  <= obuf_cnt_next;
            out_valid <= (obuf_cnt_next != 2'd0);
            // Head loads from memory when empty, or when the single held word retires as a new one arrives.
            if (rinc && ((obuf_cnt == 2'd0) || ((obuf_cnt == 2'd1) && xfer))) begin
                out_data <= rdata;
            end else if (xfer && (obuf_cnt == 2'd2)) begin
                out_data <= obuf_tail;
            end
            if (rinc && (obuf_cnt == 2'd1) && !xfer) begin
                obuf_tail <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_rptr_empty_buf.sv
// Self-checking bench for rptr_empty_buf: table-driven backpressure walk plus hand-written corner sequences.
// Latency: n/a (bench).
// Backpressure: out_ready driven from the table, constants and $urandom.
module tb_rptr_empty_buf;

    logic       rclk;
    logic       rrst;
    logic [4:0] rq2_wptr;
    logic [7:0] rdata;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic [4:0] rlevel;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    logic [7:0] mem [16];
    logic [4:0] wbin;
    logic [7:0] sb_q [$];
    int         checks;
    int         failures;
    int         nrecv;

    typedef struct {
        int         nwr;
        logic       rdy;
        logic       exp_empty;
        logic [4:0] exp_level;
        logic [4:0] exp_rptr;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [11];

    rptr_empty_buf #(.DSIZE(8), .ASIZE(4)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rq2_wptr  (rq2_wptr),
        .rdata     (rdata),
        .raddr     (raddr),
        .rptr      (rptr),
        .rempty    (rempty),
        .rlevel    (rlevel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign rdata = mem[raddr];

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [4:0] bin2gray(input logic [4:0] b);
        return (b >> 1) ^ b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Writer side: store a word, advance the write pointer and record the expected output.
    task automatic wr(input logic [7:0] word);
        mem[wbin[3:0]] = word;
        wbin = wbin + 5'd1;
        rq2_wptr = bin2gray(wbin);
        sb_q.push_back(word);
    endtask

    // Called at a negedge with inputs settled: score any transfer at the coming edge, then advance.
    task automatic tick();
        logic [7:0] exp;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%0h expected=none", out_data);
            end else begin
                exp = sb_q.pop_front();
                chk("sb_data", {24'd0, out_data}, {24'd0, exp});
            end
            nrecv++;
        end
        @(negedge rclk);
    endtask

    task automatic reset_dut();
        rrst      = 1'b1;
        out_ready = 1'b0;
        wbin      = 5'd0;
        rq2_wptr  = 5'd0;
        tick();
        tick();
        rrst = 1'b0;
        sb_q.delete();
        nrecv = 0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        nrecv     = 0;
        rrst      = 1'b1;
        out_ready = 1'b0;
        rq2_wptr  = 5'd0;
        wbin      = 5'd0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        //            nwr rdy  empty level  rptr   valid data
        vecs[0]  = '{5, 1'b0, 1'b0, 5'd5, 5'd0, 1'b0, 8'h00};
        vecs[1]  = '{0, 1'b0, 1'b0, 5'd4, 5'd1, 1'b1, 8'hA0};
        vecs[2]  = '{0, 1'b0, 1'b0, 5'd3, 5'd3, 1'b1, 8'hA0};
        vecs[3]  = '{0, 1'b0, 1'b0, 5'd3, 5'd3, 1'b1, 8'hA0};
        vecs[4]  = '{0, 1'b0, 1'b0, 5'd3, 5'd3, 1'b1, 8'hA0};
        vecs[5]  = '{0, 1'b1, 1'b0, 5'd3, 5'd3, 1'b1, 8'hA1};
        vecs[6]  = '{0, 1'b1, 1'b0, 5'd2, 5'd2, 1'b1, 8'hA2};
        vecs[7]  = '{0, 1'b1, 1'b0, 5'd1, 5'd6, 1'b1, 8'hA3};
        vecs[8]  = '{0, 1'b1, 1'b1, 5'd0, 5'd7, 1'b1, 8'hA4};
        vecs[9]  = '{0, 1'b1, 1'b1, 5'd0, 5'd7, 1'b0, 8'h00};
        vecs[10] = '{0, 1'b1, 1'b1, 5'd0, 5'd7, 1'b0, 8'h00};

        @(negedge rclk);
        reset_dut();

        // Idle after reset: nothing moves for 20 cycles.
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("idle_rempty", {31'd0, rempty}, 32'd1);
            chk("idle_valid", {31'd0, out_valid}, 32'd0);
            chk("idle_raddr", {28'd0, raddr}, 32'd0);
            chk("idle_rptr", {27'd0, rptr}, 32'd0);
            chk("idle_rlevel", {27'd0, rlevel}, 32'd0);
            chk("idle_data", {24'd0, out_data}, 32'd0);
        end

        // Three words, out_ready high: two-cycle first latency then back-to-back.
        reset_dut();
        out_ready = 1'b1;
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        tick();
        chk("lat_e1_rempty", {31'd0, rempty}, 32'd0);
        chk("lat_e1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("lat_e2_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_e2_data", {24'd0, out_data}, 32'h11);
        tick();
        chk("lat_e3_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_e3_data", {24'd0, out_data}, 32'h22);
        tick();
        chk("lat_e4_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_e4_data", {24'd0, out_data}, 32'h33);
        tick();
        chk("lat_end_valid", {31'd0, out_valid}, 32'd0);
        chk("lat_end_rptr", {27'd0, rptr}, 32'd2);
        chk("lat_end_rempty", {31'd0, rempty}, 32'd1);
        chk("lat_end_rlevel", {27'd0, rlevel}, 32'd0);
        chk("lat_recv", nrecv, 32'd3);

        // Table walk: five words under backpressure, then release.
        reset_dut();
        for (int v = 0; v < 11; v++) begin
            for (int k = 0; k < vecs[v].nwr; k++) wr(8'hA0 + 8'(k));
            out_ready = vecs[v].rdy;
            tick();
            chk($sformatf("vec%0d_rempty", v), {31'd0, rempty}, {31'd0, vecs[v].exp_empty});
            chk($sformatf("vec%0d_rlevel", v), {27'd0, rlevel}, {27'd0, vecs[v].exp_level});
            chk($sformatf("vec%0d_rptr", v), {27'd0, rptr}, {27'd0, vecs[v].exp_rptr});
            chk($sformatf("vec%0d_valid", v), {31'd0, out_valid}, {31'd0, vecs[v].exp_valid});
            if (vecs[v].exp_valid)
                chk($sformatf("vec%0d_data", v), {24'd0, out_data}, {24'd0, vecs[v].exp_data});
        end
        chk("vec_recv", nrecv, 32'd5);

        // Random stream of 40 words with random backpressure; read pointer wraps past 31.
        reset_dut();
        begin
            int written;
            int cyc;
            written = 0;
            cyc = 0;
            while ((nrecv < 40) && (cyc < 3000)) begin
                if ((written < 40) && (sb_q.size() < 16) && ($urandom_range(0, 3) != 0)) begin
                    wr(8'($urandom));
                    written++;
                end
                out_ready = 1'($urandom_range(0, 1));
                tick();
                cyc++;
            end
        end
        chk("rnd_recv", nrecv, 32'd40);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("rnd_rempty", {31'd0, rempty}, 32'd1);
        chk("rnd_valid", {31'd0, out_valid}, 32'd0);
        chk("rnd_rptr", {27'd0, rptr}, {27'd0, bin2gray(5'd8)});
        chk("rnd_rlevel", {27'd0, rlevel}, 32'd0);
        chk("rnd_left", sb_q.size(), 32'd0);

        // Full memory: write pointer equals read pointer except for the wrap bit.
        reset_dut();
        for (int k = 0; k < 16; k++) wr(8'h40 + 8'(k));
        tick();
        chk("full_rempty", {31'd0, rempty}, 32'd0);
        chk("full_rlevel", {27'd0, rlevel}, 32'd16);
        chk("full_rptr", {27'd0, rptr}, 32'd0);
        out_ready = 1'b1;
        for (int c = 0; (c < 200) && (nrecv < 16); c++) tick();
        chk("full_recv", nrecv, 32'd16);
        tick();
        tick();
        chk("full_end_rempty", {31'd0, rempty}, 32'd1);
        chk("full_end_valid", {31'd0, out_valid}, 32'd0);
        chk("full_end_rptr", {27'd0, rptr}, {27'd0, bin2gray(5'd16)});

        // Reset mid-operation with a full output buffer and four words still in memory.
        reset_dut();
        for (int k = 0; k < 6; k++) wr(8'h60 + 8'(k));
        tick();
        tick();
        tick();
        tick();
        chk("mid_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("mid_pre_rlevel", {27'd0, rlevel}, 32'd4);
        chk("mid_pre_data", {24'd0, out_data}, 32'h60);
        rrst     = 1'b1;
        wbin     = 5'd0;
        rq2_wptr = 5'd0;
        tick();
        chk("mid_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rempty", {31'd0, rempty}, 32'd1);
        chk("mid_rptr", {27'd0, rptr}, 32'd0);
        chk("mid_rlevel", {27'd0, rlevel}, 32'd0);
        chk("mid_data", {24'd0, out_data}, 32'd0);
        rrst = 1'b0;
        sb_q.delete();
        nrecv = 0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("mid_after_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_after_recv", nrecv, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
